// File: rtl/dest_tag_queue_pkg.sv
// rtl/dest_tag_queue_pkg.sv - shared constants for the destination-tag queue
package dest_tag_queue_pkg;

  localparam int TAG_W  = 5;
  localparam int QDEPTH = 32;
  localparam int PTR_W  = 5;
  localparam int CNT_W  = 6;

  // r0 is hardwired to zero and never written, so it never carries a hazard
  localparam logic [TAG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dest_tag_queue_mux.sv
// rtl/dest_tag_queue_mux.sv - 32:1 x 5-bit head-read multiplexer
module mux_32_5 (
  input  logic [4:0] in0,
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  input  logic [4:0] in3,
  input  logic [4:0] in4,
  input  logic [4:0] in5,
  input  logic [4:0] in6,
  input  logic [4:0] in7,
  input  logic [4:0] in8,
  input  logic [4:0] in9,
  input  logic [4:0] in10,
  input  logic [4:0] in11,
  input  logic [4:0] in12,
  input  logic [4:0] in13,
  input  logic [4:0] in14,
  input  logic [4:0] in15,
  input  logic [4:0] in16,
  input  logic [4:0] in17,
  input  logic [4:0] in18,
  input  logic [4:0] in19,
  input  logic [4:0] in20,
  input  logic [4:0] in21,
  input  logic [4:0] in22,
  input  logic [4:0] in23,
  input  logic [4:0] in24,
  input  logic [4:0] in25,
  input  logic [4:0] in26,
  input  logic [4:0] in27,
  input  logic [4:0] in28,
  input  logic [4:0] in29,
  input  logic [4:0] in30,
  input  logic [4:0] in31,
  input  logic [4:0] select,
  output logic [4:0] out
);

  logic [4:0] ins [32];

  assign ins = '{in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
                 in8,  in9,  in10, in11, in12, in13, in14, in15,
                 in16, in17, in18, in19, in20, in21, in22, in23,
                 in24, in25, in26, in27, in28, in29, in30, in31};

  // Pure select; every select value maps to exactly one input
  always_comb begin
    out = ins[select];
  end

endmodule

// File: rtl/dest_tag_queue.sv
// rtl/dest_tag_queue.sv - in-flight destination-tag FIFO with two-port hazard lookup
module dest_tag_queue
  import dest_tag_queue_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [TAG_W-1:0] push_tag,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [TAG_W-1:0] pop_tag,
  output logic [CNT_W-1:0] count,
  input  logic [TAG_W-1:0] query_a,
  input  logic [TAG_W-1:0] query_b,
  output logic             hazard_a,
  output logic             hazard_b
);

  logic [TAG_W-1:0]  mem_q [QDEPTH];
  logic [QDEPTH-1:0] valid_q,  valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic full, empty, push_fire, pop_fire;

  assign full       = (count_q == CNT_W'(QDEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign count      = count_q;

  // Handshakes are gated by the flags of the current state, so a pop never
  // frees space for a same-cycle push and a push never falls through to pop
  assign push_fire  = push_valid && !full;
  assign pop_fire   = pop_ready && !empty;

  // Next-state for pointers, valid bits and occupancy; flush dominates
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      valid_d  = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fire) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push_fire && !pop_fire) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_fire && !push_fire) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; cleared on reset so the head read is 0 out of reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_fire && !flush) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

  mux_32_5 u_head_mux (
    .in0   (mem_q[0]),
    .in1   (mem_q[1]),
    .in2   (mem_q[2]),
    .in3   (mem_q[3]),
    .in4   (mem_q[4]),
    .in5   (mem_q[5]),
    .in6   (mem_q[6]),
    .in7   (mem_q[7]),
    .in8   (mem_q[8]),
    .in9   (mem_q[9]),
    .in10  (mem_q[10]),
    .in11  (mem_q[11]),
    .in12  (mem_q[12]),
    .in13  (mem_q[13]),
    .in14  (mem_q[14]),
    .in15  (mem_q[15]),
    .in16  (mem_q[16]),
    .in17  (mem_q[17]),
    .in18  (mem_q[18]),
    .in19  (mem_q[19]),
    .in20  (mem_q[20]),
    .in21  (mem_q[21]),
    .in22  (mem_q[22]),
    .in23  (mem_q[23]),
    .in24  (mem_q[24]),
    .in25  (mem_q[25]),
    .in26  (mem_q[26]),
    .in27  (mem_q[27]),
    .in28  (mem_q[28]),
    .in29  (mem_q[29]),
    .in30  (mem_q[30]),
    .in31  (mem_q[31]),
    .select(rd_ptr_q),
    .out   (pop_tag)
  );

  // Hazard lookup sees registered state only; an in-flight push is the
  // decoder's responsibility to compare against push_tag directly
  logic [QDEPTH-1:0] match_a, match_b;

  for (genvar i = 0; i < QDEPTH; i++) begin : g_cmp
    assign match_a[i] = valid_q[i] && (mem_q[i] == query_a);
    assign match_b[i] = valid_q[i] && (mem_q[i] == query_b);
  end

  assign hazard_a = (query_a != REG_ZERO) && (|match_a);
  assign hazard_b = (query_b != REG_ZERO) && (|match_b);

endmodule

// File: doc/dest_tag_queue.md
# dest_tag_queue

32-entry FIFO of 5-bit destination-register tags for multi-cycle (mult/div) operations in flight. Storage entries plus the read pointer drive the existing `mux_32_5` head-read stage, so the queue feeds that stage directly. It also provides two-port hazard lookup so decode can stall on a source register with a pending write. Sits between issue (push) and writeback (pop).

## Interface
- `DEPTH` — 32 — number of entries; fixed by the 32:1 read mux.
- `TAG_W` — 5 — tag width, i.e. register index width.
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `flush` in 1 — synchronous clear of all entries.
- `push_valid` in 1 — issue presents a tag.
- `push_ready` out 1 — queue can accept; equals `!full`.
- `push_tag` in 5 — destination register index.
- `pop_valid` out 1 — head entry present; equals `!empty`.
- `pop_ready` in 1 — writeback consumes the head.
- `pop_tag` out 5 — head tag, via `mux_32_5` with select = `rd_ptr`.
- `count` out 6 — occupancy, 0..32.
- `query_a`, `query_b` in 5 — decode source registers.
- `hazard_a`, `hazard_b` out 1 — query matches a valid queued tag.

## Operation
- **State:**
  - `mem[0..31]` (5 b each)
  - `valid[31:0]`
  - `wr_ptr`, `rd_ptr` (5 b, natural wrap 31→0)
  - `count` (6 b)
- **Push:** fires when `push_valid && push_ready`.
  - `mem[wr_ptr] <= push_tag`; `valid[wr_ptr] <= 1`; `wr_ptr++`.
- **Pop:** fires when `pop_valid && pop_ready`.
  - `valid[rd_ptr] <= 0`; `rd_ptr++`.
- **Count update:**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. Both fire at `count` 1..31.
  - At `count`=0 only a push can fire; at `count`=32 only a pop can fire.
  - No fall-through, and no push-when-full even with a simultaneous pop.
- **Flags:** full = (`count`==32); empty = (`count`==0).
- **Flush:**
  - Clears `valid`, both pointers and `count`. `mem` contents are retained but irrelevant.
  - Overrides any push or pop in the same cycle.
- **Hazard:**
  - `hazard_x` = OR over i of (`valid[i]` && `mem[i]`==`query_x`), forced 0 when `query_x`==0, since r0 is never written.
  - Purely combinational from registered state.
  - A tag being pushed in the current cycle is not reported; decode compares against `push_tag` itself.
- **Tag values:** not checked. Duplicate tags are legal; hazard stays asserted until every matching entry has popped.
- **`pop_tag` when empty:** don't-care; must not be used.

## Timing
- **Reset values:**
  - `push_ready`=1, `pop_valid`=0, `count`=0, `hazard_a`/`hazard_b`=0.
  - `pop_tag`=0, because `mem` resets to all zero.
  - Reset is asynchronous and takes effect immediately, including mid-operation; no handshake completes in a cycle where `reset` is high.
- **Push→pop latency:** 1 cycle. A tag pushed at edge N appears on `pop_tag`, with `pop_valid`=1, after edge N.
- **Hazard timing:**
  - Pushed at edge N: visible on `hazard_*` from N+1.
  - Popped at edge N: cleared from N+1.
- **Flush:** asserted during cycle N; outputs show the empty state after edge N.
- **Wrap:** pointers wrap 31→0 with no bubble; 33 consecutive push/pop pairs exercise the wrap.
- **Critical path:** `rd_ptr` → `mux_32_5` → `pop_tag`, and the 32-way compare/OR for hazard. Both must close at the processor clock.

## Structure
- **Shared package** (`proc_pkg` or equivalent): `TAG_W`=5, `QDEPTH`=32, `PTR_W`=5, `CNT_W`=6, and the r0 constant `REG_ZERO`=5'd0.
- **Sub-module:** instantiate the existing `mux_32_5` for the head read.
  - Inputs `in0..in31` = `mem[0..31]`; `select` = `rd_ptr`.
  - Build no second read mux.
- **Hazard comparator:** one generate loop of 32 equality compares per query port. No further sub-module.

## Test plan
- **Reset/idle:** assert `reset` mid-stream with `count`=5 → `count`=0, `pop_valid`=0, `push_ready`=1, `hazard_*`=0 immediately; the next push of tag 7 pops as 7.
- **Fill/drain:**
  - Push tags 1..31 then 1 (32 pushes) → `push_ready`=0 and `count`=32.
  - A 33rd push is ignored.
  - Pops return 1..31,1 in order, then `pop_valid`=0.
- **Simultaneous push/pop:**
  - At `count`=4, push 9 and pop together → `count` stays 4 and `pop_tag` advances.
  - At `count`=0, push and `pop_ready` together → only the push fires; `count`=1.
- **Wrap-around:** 40 back-to-back push/pop pairs of tags i mod 32 → FIFO order is preserved across pointer wrap and `count` stays 1.
- **Hazard:**
  - Push 12 → `hazard_a`(`query_a`=12)=1 next cycle; `query_a`=0 → 0.
  - Push 12 twice, pop once → still 1; second pop → 0.
  - Same-cycle push of 12 with `query_a`=12 → 0 that cycle.
- **Flush:** `flush` with `count`=10 plus a simultaneous push → `count`=0, `hazard_*`=0, `pop_valid`=0; the pushed tag is dropped.
